shared_adder_arbiter: RTL
=========================

SHARED_ADDER_ARBITER -- requirements
Module: shared_adder_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; SHALL be a multiple of 4 and >= 4.
REQ-002 Derived constant: NIB = WIDTH/4, the number of nibble steps per addition.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous and active-low.
REQ-005 Port: req0  input  1  requester 0 level request; held high until done0.
REQ-006 Port: opa0, opb0  input  WIDTH  requester 0 operands.
REQ-007 Port: cin0  input  1  requester 0 carry-in.
REQ-008 Port: req1, opa1, opb1, cin1  input  1/WIDTH/WIDTH/1  requester 1 equivalents.
REQ-009 Port: done0, done1  output  1  one-cycle completion pulse to the served requester.
REQ-010 Port: sum  output  WIDTH  registered result of the last completed addition.
REQ-011 Port: cout  output  1  registered final carry of the last completed addition.
REQ-012 Port: busy  output  1  high in every state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ADD and DONE.
REQ-014 IDLE, no request: remain in IDLE.
REQ-015 IDLE, one request: grant that requester.
REQ-016 IDLE, both requests: grant the requester not served last (round-robin); the pointer SHALL favour requester 0 after reset.
REQ-017 At the grant edge, capture opa, opb and cin of the granted requester into internal registers; clear the nibble index to 0; record the granted id; update the round-robin pointer; go to ADD.
REQ-018 Each ADD edge SHALL add nibble[idx] of both captured operands plus the carry register; write the 4-bit sum into result bits [4*idx+3:4*idx]; store the carry-out in the carry register; increment idx.
REQ-019 For nibble 0 the carry-in SHALL be the captured cin.
REQ-020 On the edge that processes nibble NIB-1, load sum and cout, then go to DONE.
REQ-021 In DONE, assert exactly one of done0/done1, matching the recorded id, for exactly one cycle, then return to IDLE.
REQ-022 Latency: the done pulse SHALL be visible NIB edges after the grant edge; the next grant SHALL occur no earlier than NIB+2 edges after the previous grant.
REQ-023 Requests arriving during ADD or DONE SHALL be ignored until IDLE; no request is lost while it stays high.
REQ-024 A request still high in the cycle after done SHALL be treated as a new request.
REQ-025 Operand changes after the grant edge SHALL NOT affect the in-flight result.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH; cout SHALL be the carry out of bit WIDTH-1.
REQ-027 sum and cout SHALL hold their value until the next DONE load.

Reset
REQ-028 While rst_n is low: state = IDLE, idx = 0, carry = 0, pointer = requester 0, sum = 0, cout = 0, done0 = done1 = 0, busy = 0.
REQ-029 Reset asserted mid-ADD or mid-DONE SHALL abort the operation with no done pulse; the first request after reset release SHALL be served normally.

Structure
REQ-030 The FSM state encodings and the nibble width constant (4) SHALL live in a shared package or include file.
REQ-031 The nibble datapath SHALL be one instance of the existing four_bit_adder sub-module, driven bitwise from the captured-operand slice and the carry register.
REQ-032 Nibble slice selection SHALL be a mux indexed by idx; the result SHALL be assembled in a WIDTH-bit register.

Verification
REQ-033 req0, opa0=0x1234, opb0=0x0FCD, cin0=0 -> done0 4 edges after grant, sum=0x2201, cout=0, done1 never asserted.
REQ-034 req1, opa1=0xFFFF, opb1=0x0000, cin1=1 -> sum=0x0000, cout=1 (carry ripples through all nibbles).
REQ-035 req0 and req1 held high from reset release with constant operands -> grants alternate 0,1,0,1 and each done pulse is one cycle wide.
REQ-036 req1 (0x8000+0x8000) raised during requester 0's ADD -> requester 0 completes first; requester 1 is granted in the next IDLE with sum=0x0000, cout=1.
REQ-037 rst_n pulsed low during ADD nibble 2 -> no done pulse, all outputs 0; a following req0 with 0x0001+0x0001 yields sum=0x0002.
REQ-038 opa0 changed to 0xAAAA one cycle after grant of 0x0001+0x0002 -> sum=0x0003.

Source files
------------

// File: rtl/shared_adder_arbiter_pkg.sv
// Shared constants and FSM encoding for the nibble-serial shared adder.
// Imported by the arbiter top and its testbench.
package shared_adder_arbiter_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the nibble index; at least one bit even for a single-nibble adder.
  function automatic int idx_bits(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/shared_adder_arbiter_adder.sv
// Four-bit ripple adder used as the single shared nibble datapath.
// Built from per-bit full-adder equations.
module four_bit_adder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < 4; g++) begin : g_bit
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[4];

endmodule

// File: rtl/shared_adder_arbiter.sv
// Two-requester round-robin arbiter in front of one nibble-serial adder.
// Handshake: reqN is a level held until doneN; the one-cycle doneN pulse is the only acknowledge.
module shared_adder_arbiter
  import shared_adder_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] opa0,
  input  logic [WIDTH-1:0] opb0,
  input  logic             cin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] opa1,
  input  logic [WIDTH-1:0] opb1,
  input  logic             cin1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output state_e           dbg_state
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int IW  = idx_bits(NIB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  state_e           r_state;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_prio;
  logic             r_id;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;

  logic             w_gnt_id;
  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;
  logic [3:0]       w_nib_s;
  logic             w_nib_c;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  // With both requests up, r_prio names the requester that was not served last.
  assign w_gnt_id = (req0 && req1) ? r_prio : req1;

  always_comb begin
    w_nib_a = r_opa[NIB_W*r_idx +: NIB_W];
    w_nib_b = r_opb[NIB_W*r_idx +: NIB_W];
  end

  four_bit_adder u_nib (
    .i_a    (w_nib_a),
    .i_b    (w_nib_b),
    .i_cin  (r_carry),
    .o_sum  (w_nib_s),
    .o_cout (w_nib_c)
  );

  always_comb begin
    w_res_next = r_res;
    w_res_next[NIB_W*r_idx +: NIB_W] = w_nib_s;
  end

  assign w_last    = (r_idx == LAST_IDX);
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_prio  <= 1'b0;
      r_id    <= 1'b0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req0 || req1) begin
            r_id    <= w_gnt_id;
            r_prio  <= ~w_gnt_id;
            r_opa   <= w_gnt_id ? opa1 : opa0;
            r_opb   <= w_gnt_id ? opb1 : opb0;
            // The carry register doubles as the nibble-0 carry-in.
            r_carry <= w_gnt_id ? cin1 : cin0;
            r_idx   <= '0;
            r_state <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_res   <= w_res_next;
          r_carry <= w_nib_c;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            sum     <= w_res_next;
            cout    <= w_nib_c;
            done0   <= ~r_id;
            done1   <= r_id;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
